dispense_sequencer: RTL and testbench
=====================================

# dispense_sequencer

Downstream stage of `coffee_machine`: once payment for a drink is accepted, it receives a one-cycle start request and the 3-bit drink code. It then drives the ingredient valves (`water`, `coffee`, `milk`, `chocolate`, `sugar`) one at a time, in a fixed order and for fixed durations. When the drink is complete it pulses `finished`. It owns all valve timing, so upstream logic only handles coins, selection and confirmation.

## Interface
- `STEP_CYCLES`, default 4: clock cycles each valve stays open; legal range 1..255.
- `clock` in 1: system clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high; returns the block to IDLE.
- `start` in 1: one-cycle request from the payment stage; sampled only in IDLE.
- `coffee_type` in 3: drink code, latched on the cycle `start` is sampled high.
- `abort` in 1: present only when `DISPENSE_ABORT_EN` is defined (see Configuration).
- `busy` out 1: high while a drink is being dispensed.
- `water` out 1: water valve.
- `coffee` out 1: coffee valve.
- `milk` out 1: milk valve.
- `chocolate` out 1: chocolate valve.
- `sugar` out 1: sugar valve.
- `finished` out 1: one-cycle completion pulse.
- `bad_type` out 1: one-cycle pulse when `start` arrives with an undefined drink code.

## Operation
- Drink codes and recipes:
  - 3'b001 espresso: water, coffee.
  - 3'b010 americano: water, coffee, sugar.
  - 3'b011 cappuccino: water, coffee, milk, sugar.
  - 3'b100 mocha: water, coffee, milk, chocolate, sugar.
  - 3'b101 hot chocolate: water, milk, chocolate.
  - 3'b000, 3'b110 and 3'b111 are undefined.
- States: IDLE, WATER, COFFEE, MILK, CHOCOLATE, SUGAR, DONE.
- Steps always run in the order WATER→COFFEE→MILK→CHOCOLATE→SUGAR; steps not in the latched recipe are skipped with zero cycles spent.
- IDLE:
  - `start`=1 with a defined code: latch the code, go to the first recipe step.
  - `start`=1 with an undefined code: pulse `bad_type` next cycle, stay in IDLE.
- Each step state drives exactly its valve high and all other valves low; valves are never open simultaneously.
- A down-counter sized for `STEP_CYCLES` is loaded on step entry. When it expires, the FSM moves to the next recipe step, or to DONE after the last one.
- DONE: `finished`=1 for one cycle, then return to IDLE.
- `start` is ignored in every state other than IDLE; there is no queueing.
- `coffee_type` changes after the latch cycle have no effect on the drink in progress.
- All outputs are registered.
- Reset values: every output 0, state IDLE, counter 0, latched code 3'b000.

## Timing
- `start` sampled high at edge N: first valve is high from cycle N+1.
- Each valve is high for exactly `STEP_CYCLES` consecutive cycles. The next valve rises in the cycle immediately after the previous one falls, with no gap and no overlap.
- For a recipe of k steps, `finished` is high in cycle N+1+k·`STEP_CYCLES`.
- `busy` is high from N+1 through the `finished` cycle inclusive, and low in the following cycle.
- A new `start` is accepted no earlier than the cycle after `finished`. Back-to-back drinks are therefore separated by one IDLE cycle.
- `bad_type` is high in cycle N+1 only; `busy` stays 0.
- `reset` high at any edge, including mid-step: all valves are 0 on the next cycle, and the partial drink is discarded with no `finished` pulse.
- `reset` and `start` high at the same edge: reset wins and `start` is dropped.

## Configuration
- `DISPENSE_ABORT_EN` defined:
  - `abort` input port exists.
  - `abort`=1 in any step state closes all valves on the next cycle and goes to DONE.
  - `finished` pulses as normal.
  - `abort` in IDLE or DONE is ignored.
- `DISPENSE_ABORT_EN` undefined: no `abort` port; every accepted drink runs to completion unless `reset` is asserted.

## Test plan
- `STEP_CYCLES`=4, espresso (3'b001) start at cycle 0:
  - `water` high cycles 1–4, `coffee` high cycles 5–8, `finished` high at cycle 9.
  - `busy` high cycles 1–9.
- Mocha (3'b100):
  - water 1–4, coffee 5–8, milk 9–12, chocolate 13–16, sugar 17–20.
  - `finished` high at cycle 21; `coffee_type` toggled mid-drink has no effect.
- Hot chocolate (3'b101): water 1–4, milk 5–8, chocolate 9–12, `finished` at 13; `coffee` and `sugar` never rise.
- `start` with 3'b111:
  - `bad_type` high at cycle 1.
  - `busy` and all valves remain 0.
  - A valid `start` at cycle 2 is accepted.
- Reset mid-drink and repeated start:
  - `reset` asserted at cycle 6 of a cappuccino: all outputs 0 from cycle 7, no `finished`.
  - `start` pulses during a drink are ignored.
- With `DISPENSE_ABORT_EN`: `abort` at cycle 3 of an americano gives `water` low from cycle 4 and `finished` at cycle 4.

Source files
------------

// File: rtl/dispense_sequencer.sv
// -----------------------------------------------------------------------------
// dispense_sequencer
//
// Purpose:
//   Drink dispensing sequencer that sits behind the coffee_machine payment
//   stage. A one-cycle start request carries a 3-bit drink code. The code is
//   latched and the ingredient valves are opened one at a time, in the fixed
//   order WATER -> COFFEE -> MILK -> CHOCOLATE -> SUGAR. Each valve stays open
//   for STEP_CYCLES clocks. Steps that are not part of the latched recipe are
//   skipped without spending a cycle. A one-cycle 'finished' pulse marks the
//   end of the drink.
//
// Parameters:
//   STEP_CYCLES  clock cycles each valve stays open (1..255, default 4)
//
// Ports:
//   clock        system clock, rising-edge
//   reset        synchronous active-high reset, returns to IDLE
//   start        one-cycle request, only honoured in IDLE
//   coffee_type  drink code, latched when start is accepted
//   abort        (DISPENSE_ABORT_EN only) cut the current drink short
//   busy         high from the first valve cycle through the finished cycle
//   water, coffee, milk, chocolate, sugar   valve drives, at most one high
//   finished     one-cycle completion pulse
//   bad_type     one-cycle pulse when start carries an undefined code
//
// Configuration macro:
//   DISPENSE_ABORT_EN  when defined, adds the 'abort' input. Asserting abort in
//                      any valve step closes all valves on the next cycle and
//                      finishes the drink through DONE.
//
// Every output is driven straight from a flop. Each registered output is
// computed from the next state, so it lines up with the state it describes.
// -----------------------------------------------------------------------------
module dispense_sequencer #(
   parameter int unsigned STEP_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] coffee_type,
`ifdef DISPENSE_ABORT_EN
   input  logic       abort,
`endif
   output logic       busy,
   output logic       water,
   output logic       coffee,
   output logic       milk,
   output logic       chocolate,
   output logic       sugar,
   output logic       finished,
   output logic       bad_type
);

   // Counter only needs to hold STEP_CYCLES-1, but it keeps at least one bit.
   localparam int unsigned     CNT_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEP_CYCLES - 1);

   // The encoding order matches the dispensing order, and step_after relies on it.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WATER     = 3'd1,
      COFFEE    = 3'd2,
      MILK      = 3'd3,
      CHOCOLATE = 3'd4,
      SUGAR     = 3'd5,
      DONE      = 3'd6
   } state_t;

   // Recipe mask bit order: [0] water, [1] coffee, [2] milk, [3] chocolate, [4] sugar.
   // An all-zero mask marks an undefined drink code.
   function automatic logic [4:0] recipe_mask(input logic [2:0] code);
      logic [4:0] m;
      case (code)
         3'b001:  m = 5'b00011;   // espresso
         3'b010:  m = 5'b10011;   // americano
         3'b011:  m = 5'b10111;   // cappuccino
         3'b100:  m = 5'b11111;   // mocha
         3'b101:  m = 5'b01101;   // hot chocolate
         default: m = 5'b00000;
      endcase
      return m;
   endfunction

   // Returns the first recipe step that comes strictly after 'cur', or DONE if
   // none is left. The checks run from the last step to the first, so the
   // earliest qualifying step is the one that remains assigned.
   function automatic state_t step_after(input state_t cur, input logic [4:0] m);
      state_t r;
      r = DONE;
      if (m[4] && (cur < SUGAR))     r = SUGAR;
      if (m[3] && (cur < CHOCOLATE)) r = CHOCOLATE;
      if (m[2] && (cur < MILK))      r = MILK;
      if (m[1] && (cur < COFFEE))    r = COFFEE;
      if (m[0] && (cur < WATER))     r = WATER;
      return r;
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       type_q, type_d;
   logic             busy_q, busy_d;
   logic [4:0]       valve_q, valve_d;
   logic             finished_q, finished_d;
   logic             bad_type_q, bad_type_d;

   logic [4:0]       start_mask;
   logic [4:0]       latched_mask;
   logic             step_entry;

   assign start_mask   = recipe_mask(coffee_type);
   assign latched_mask = recipe_mask(type_q);

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d    = state_q;
      type_d     = type_q;
      bad_type_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (start_mask != 5'b00000) begin
                  type_d  = coffee_type;
                  state_d = step_after(IDLE, start_mask);
               end else begin
                  bad_type_d = 1'b1;
               end
            end
         end

         WATER, COFFEE, MILK, CHOCOLATE, SUGAR: begin
`ifdef DISPENSE_ABORT_EN
            if (abort) begin
               state_d = DONE;
            end else
`endif
            if (cnt_q == '0) begin
               state_d = step_after(state_q, latched_mask);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------- step timer
   // The counter is reloaded whenever a step is entered, including a direct
   // step-to-step hand-off. It counts down while the step holds and is cleared
   // outside the step states.
   assign step_entry = (state_d != state_q) &&
                       (state_d != IDLE) && (state_d != DONE);

   always_comb begin
      cnt_d = '0;
      if (step_entry) begin
         cnt_d = CNT_LOAD;
      end else if ((state_d == state_q) && (state_q != IDLE) && (state_q != DONE)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // --------------------------------------------------------- registered outputs
   // The outputs are decoded from state_d, so each registered output is valid
   // in the same cycle as the state it belongs to.
   always_comb begin
      valve_d    = 5'b00000;
      valve_d[0] = (state_d == WATER);
      valve_d[1] = (state_d == COFFEE);
      valve_d[2] = (state_d == MILK);
      valve_d[3] = (state_d == CHOCOLATE);
      valve_d[4] = (state_d == SUGAR);
      busy_d     = (state_d != IDLE);
      finished_d = (state_d == DONE);
   end

   // ------------------------------------------------------------------- flops
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         type_q     <= 3'b000;
         busy_q     <= 1'b0;
         valve_q    <= 5'b00000;
         finished_q <= 1'b0;
         bad_type_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         type_q     <= type_d;
         busy_q     <= busy_d;
         valve_q    <= valve_d;
         finished_q <= finished_d;
         bad_type_q <= bad_type_d;
      end
   end

   assign busy      = busy_q;
   assign water     = valve_q[0];
   assign coffee    = valve_q[1];
   assign milk      = valve_q[2];
   assign chocolate = valve_q[3];
   assign sugar     = valve_q[4];
   assign finished  = finished_q;
   assign bad_type  = bad_type_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dispense_sequencer
//
// Directed testbench for dispense_sequencer with STEP_CYCLES = 4. Cycle 0 of
// each drink is the cycle in which 'start' is held high. Outputs are sampled
// on the falling edge of cycle c and packed as
// {busy, water, coffee, milk, chocolate, sugar, finished, bad_type}.
// The bench compares them with hand-written valve windows for each drink.
// -----------------------------------------------------------------------------
module tb_dispense_sequencer;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] coffee_type;
   logic       abort_drv;
   logic       busy, water, coffee, milk, chocolate, sugar, finished, bad_type;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Valve windows for the drink under test, in the order
   // water, coffee, milk, chocolate, sugar. Both bounds are inclusive, and a
   // start value of 0 means the valve never opens.
   int ws[5];
   int we[5];

   always #5 clock = ~clock;

   dispense_sequencer #(.STEP_CYCLES(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .coffee_type (coffee_type),
`ifdef DISPENSE_ABORT_EN
      .abort       (abort_drv),
`endif
      .busy        (busy),
      .water       (water),
      .coffee      (coffee),
      .milk        (milk),
      .chocolate   (chocolate),
      .sugar       (sugar),
      .finished    (finished),
      .bad_type    (bad_type)
   );

   function automatic logic [7:0] outs();
      return {busy, water, coffee, milk, chocolate, sugar, finished, bad_type};
   endfunction

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end else begin
         $display("ok   %s: %b", tag, got);
      end
   endtask

   // Advance into the next cycle. Inputs change 1 ns after the rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Start a drink in the current cycle (cycle 0) and check cycles 1..last.
   // The side stimuli (extra start, code toggle, reset, abort) are each held
   // high for the one cycle given. A value of 0 disables that stimulus.
   task automatic run_drink(input string name, input logic [2:0] code,
                            input int fin, input int busy_end, input int last,
                            input int extra_start, input int toggle_c,
                            input int reset_c, input int abort_c);
      logic [7:0] exp;
      logic [4:0] v;
      coffee_type = code;
      start       = 1'b1;
      tick();
      for (int c = 1; c <= last; c++) begin
         start     = (c == extra_start);
         reset     = (c == reset_c);
         abort_drv = (c == abort_c);
         if (c == toggle_c) coffee_type = ~coffee_type;
         @(negedge clock);
         for (int i = 0; i < 5; i++) begin
            v[i] = (ws[i] != 0) && (c >= ws[i]) && (c <= we[i]);
         end
         exp = {(c <= busy_end), v[0], v[1], v[2], v[3], v[4], (c == fin), 1'b0};
         check_eq($sformatf("%s c%0d", name, c), outs(), exp);
         if (c != last) tick();
      end
      start     = 1'b0;
      reset     = 1'b0;
      abort_drv = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      coffee_type = 3'b000;
      abort_drv   = 1'b0;
      repeat (3) tick();
      @(negedge clock);
      check_eq("reset_state", outs(), 8'b0000_0000);
      reset = 1'b0;

      // Espresso. A start during DONE (cycle 9) must be ignored.
      ws = '{1, 5, 0, 0, 0};
      we = '{4, 8, 0, 0, 0};
      run_drink("espresso", 3'b001, 9, 9, 10, 9, 0, 0, 0);

      // Americano. An extra start is pulsed during the water step.
      ws = '{1, 5, 0, 0, 9};
      we = '{4, 8, 0, 0, 12};
      run_drink("americano", 3'b010, 13, 13, 14, 3, 0, 0, 0);

      // Mocha starts right after the previous drink's trailing IDLE cycle.
      // The code is toggled mid-drink and a stray start arrives during milk.
      ws = '{1, 5, 9, 13, 17};
      we = '{4, 8, 12, 16, 20};
      run_drink("mocha", 3'b100, 21, 21, 22, 12, 6, 0, 0);

      // Hot chocolate: coffee and sugar never open.
      ws = '{1, 0, 5, 9, 0};
      we = '{4, 0, 8, 12, 0};
      run_drink("hot_choc", 3'b101, 13, 13, 14, 0, 0, 0, 0);

      // Undefined code: bad_type pulses for one cycle, then a valid start at cycle 2.
      coffee_type = 3'b111;
      start       = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clock);
      check_eq("bad_type c1", outs(), 8'b0000_0001);
      tick();
      @(negedge clock);
      check_eq("bad_type c2", outs(), 8'b0000_0000);
      ws = '{1, 5, 0, 0, 0};
      we = '{4, 8, 0, 0, 0};
      run_drink("after_bad", 3'b001, 9, 9, 10, 0, 0, 0, 0);

      // Cappuccino with reset in cycle 6: everything drops and no finished pulse follows.
      ws = '{1, 5, 0, 0, 0};
      we = '{4, 6, 0, 0, 0};
      run_drink("capp_reset", 3'b011, 0, 6, 19, 0, 0, 6, 0);

      // Reset and start at the same edge: the reset wins.
      reset       = 1'b1;
      start       = 1'b1;
      coffee_type = 3'b001;
      tick();
      reset = 1'b0;
      start = 1'b0;
      @(negedge clock);
      check_eq("rst_start c1", outs(), 8'b0000_0000);
      tick();
      @(negedge clock);
      check_eq("rst_start c2", outs(), 8'b0000_0000);

`ifdef DISPENSE_ABORT_EN
      // Americano aborted in cycle 3: water drops and finished pulses in cycle 4.
      ws = '{1, 0, 0, 0, 0};
      we = '{3, 0, 0, 0, 0};
      run_drink("amer_abort", 3'b010, 4, 4, 6, 0, 0, 0, 3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
